// File: rtl/bit_table_arbiter_pkg.sv
// bit_table_arbiter_pkg: op and FSM encodings plus the per-op bit update shared by the arbiter
package bit_table_arbiter_pkg;
  typedef logic [1:0] op_t;
  localparam op_t OP_TEST   = 2'b00;
  localparam op_t OP_SET    = 2'b01;
  localparam op_t OP_CLEAR  = 2'b10;
  localparam op_t OP_TOGGLE = 2'b11;
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
  function automatic logic apply_op(input op_t op, input logic old);
    return op == OP_TEST ? old : op == OP_SET ? 1'b1 : op == OP_CLEAR ? 1'b0 : ~old;
  endfunction
endpackage

// File: rtl/bit_ram_2p.sv
// bit_ram_2p: DEPTH x 1 bit RAM, two independent ports, async read, sync write
module bit_ram_2p #(
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we0_i,
  input  logic [AW-1:0] addr0_i,
  input  logic          d0_i,
  output logic          q0_o,
  input  logic          we1_i,
  input  logic [AW-1:0] addr1_i,
  input  logic          d1_i,
  output logic          q1_o
);
  logic mem_q [DEPTH];
  assign q0_o = mem_q[addr0_i];
  assign q1_o = mem_q[addr1_i];
  // the controller never issues both writes to one address in the same cycle
  always_ff @(posedge clk) begin
    if (we0_i) mem_q[addr0_i] <= d0_i;
    if (we1_i) mem_q[addr1_i] <= d1_i;
  end
endmodule

// File: rtl/bit_table_arbiter.sv
// bit_table_arbiter: two-port atomic test/set/clear/toggle controller over a DEPTH x 1 bit RAM,
// with a two-bits-per-cycle table clear after reset and on flush
module bit_table_arbiter import bit_table_arbiter_pkg::*; #(
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_0,
  input  logic [1:0]            req_op_0,
  input  logic [ADDR_WIDTH-1:0] req_addr_0,
  output logic                  req_ready_0,
  input  logic                  req_valid_1,
  input  logic [1:0]            req_op_1,
  input  logic [ADDR_WIDTH-1:0] req_addr_1,
  output logic                  req_ready_1,
  output logic                  rsp_valid_0,
  output logic                  rsp_q_0,
  output logic                  rsp_valid_1,
  output logic                  rsp_q_1,
  input  logic                  flush,
  output logic                  busy,
  output logic                  clr_done
);
  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic                  prio_q, prio_d;
  logic                  clr_done_q, clr_done_d;
  logic                  rsp_valid_0_q, rsp_valid_1_q, rsp_q_0_q, rsp_q_1_q;
  logic                  run, conflict, last, acc_0, acc_1;
  logic                  we_0, we_1, d_0, d_1, rd_0, rd_1;
  logic [ADDR_WIDTH-1:0] a_0, a_1;
  assign run         = state_q == ST_RUN;
  assign conflict    = req_valid_0 & req_valid_1 & (req_addr_0 == req_addr_1);
  assign req_ready_0 = run & (~conflict | ~prio_q);
  assign req_ready_1 = run & (~conflict | prio_q);
  assign acc_0       = req_valid_0 & req_ready_0;
  assign acc_1       = req_valid_1 & req_ready_1;
  assign last        = clr_addr_q == ADDR_WIDTH'(DEPTH - 2);
  // clearing borrows both RAM ports for an even/odd address pair each cycle
  assign a_0  = run ? req_addr_0 : clr_addr_q;
  assign a_1  = run ? req_addr_1 : clr_addr_q | ADDR_WIDTH'(1);
  assign we_0 = run ? acc_0 : 1'b1;
  assign we_1 = run ? acc_1 : 1'b1;
  assign d_0  = run & apply_op(req_op_0, rd_0);
  assign d_1  = run & apply_op(req_op_1, rd_1);
  always_comb begin
    state_d    = run ? (flush ? ST_CLEAR : ST_RUN) : (last ? ST_RUN : ST_CLEAR);
    clr_addr_d = (run | last) ? '0 : clr_addr_q + ADDR_WIDTH'(2);
    clr_done_d = ~run & last;
    prio_d     = prio_q ^ (run & conflict);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_CLEAR;
      clr_addr_q    <= '0;
      prio_q        <= 1'b0;
      clr_done_q    <= 1'b0;
      rsp_valid_0_q <= 1'b0;
      rsp_valid_1_q <= 1'b0;
      rsp_q_0_q     <= 1'b0;
      rsp_q_1_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_addr_q    <= clr_addr_d;
      prio_q        <= prio_d;
      clr_done_q    <= clr_done_d;
      rsp_valid_0_q <= acc_0;
      rsp_valid_1_q <= acc_1;
      rsp_q_0_q     <= acc_0 & rd_0;
      rsp_q_1_q     <= acc_1 & rd_1;
    end
  end
  assign busy        = ~run;
  assign clr_done    = clr_done_q;
  assign rsp_valid_0 = rsp_valid_0_q;
  assign rsp_valid_1 = rsp_valid_1_q;
  assign rsp_q_0     = rsp_q_0_q;
  assign rsp_q_1     = rsp_q_1_q;
  bit_ram_2p #(.DEPTH(DEPTH), .AW(ADDR_WIDTH)) u_ram (
    .clk     (clk),
    .we0_i   (we_0),
    .addr0_i (a_0),
    .d0_i    (d_0),
    .q0_o    (rd_0),
    .we1_i   (we_1),
    .addr1_i (a_1),
    .d1_i    (d_1),
    .q1_o    (rd_1)
  );
endmodule
